// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and types.
// Every datapath block takes its default data width from here.
package cpu_pkg;

    localparam int unsigned DATA_W = 16;

    typedef logic [DATA_W-1:0] data_t;

endpackage : cpu_pkg

// File: rtl/mux_2to1_core.sv
// Purely combinational 2:1 selector.
// Only a select of logic 1 picks in1. Any other select value (0, X or Z) falls back to in0.
module mux_2to1_core
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             select,
    output logic [WIDTH-1:0] y
);

    // The default-then-override form keeps an unknown select from merging X into y.
    always_comb begin
        y = in0;
        if (select) begin
            y = in1;
        end
    end

endmodule : mux_2to1_core

// File: rtl/mux_2to1.sv
// 2:1 datapath selector with a zero-latency result and a registered, valid-qualified result.
// It feeds register-file write-back and the ALU operand paths.
module mux_2to1
    import cpu_pkg::*;
#(
    parameter int unsigned      WIDTH     = DATA_W,
    parameter logic [WIDTH-1:0] RST_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             select,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out_comb,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    logic [WIDTH-1:0] sel_y;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_q;
    logic             valid_d;
    logic             valid_q;

    mux_2to1_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .in0    (in0),
        .in1    (in1),
        .select (select),
        .y      (sel_y)
    );

    // out keeps its last captured value on idle cycles; out_valid only marks fresh captures.
    always_comb begin
        out_d   = out_q;
        valid_d = in_valid;
        if (in_valid) begin
            out_d = sel_y;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= RST_VALUE;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out_comb  = sel_y;
    assign out       = out_q;
    assign out_valid = valid_q;

endmodule : mux_2to1

// File: tb/tb_mux_2to1.sv
// Bench for mux_2to1: directed steps followed by random traffic.
// Every step is checked against a rule-level reference model.
module tb_mux_2to1;

    localparam int unsigned W = 16;
    localparam logic [W-1:0] RST_V = '0;

    logic         clk;
    logic         rst;
    logic [W-1:0] in0;
    logic [W-1:0] in1;
    logic         select;
    logic         in_valid;
    logic [W-1:0] out_comb;
    logic [W-1:0] out;
    logic         out_valid;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] exp_out;
    logic         exp_valid;

    mux_2to1 #(
        .WIDTH     (W),
        .RST_VALUE (RST_V)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in0       (in0),
        .in1       (in1),
        .select    (select),
        .in_valid  (in_valid),
        .out_comb  (out_comb),
        .out       (out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, check the combinational result, clock once, then check the registers.
    task automatic step(input string tag, input logic r, input logic v, input logic s,
                        input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] pick;
        rst      = r;
        in_valid = v;
        select   = s;
        in0      = a;
        in1      = b;
        pick     = (s === 1'b1) ? b : a;
        #1;
        chk({tag, ".out_comb"}, out_comb, pick);
        @(posedge clk);
        if (r) begin
            exp_out   = RST_V;
            exp_valid = 1'b0;
        end else if (v) begin
            exp_out   = pick;
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
        #1;
        chk({tag, ".out"}, out, exp_out);
        chk({tag, ".out_valid"}, W'(out_valid), W'(exp_valid));
    endtask

    initial begin
        exp_out   = RST_V;
        exp_valid = 1'b0;

        // Reset for two edges with in_valid high; reset has priority.
        step("rst0", 1'b1, 1'b1, 1'b1, 16'h0001, 16'h0002);
        step("rst1", 1'b1, 1'b1, 1'b1, 16'h0001, 16'h0002);

        step("sel0", 1'b0, 1'b1, 1'b0, 16'h0001, 16'h0002);
        step("sel1", 1'b0, 1'b1, 1'b1, 16'h0001, 16'h0002);

        // Hold: out stays 2 while out_comb tracks select.
        for (int i = 0; i < 4; i++) begin
            step("hold", 1'b0, 1'b0, 1'(i % 2), 16'hAAAA, 16'h5555);
        end

        // Width extremes, select toggling every cycle.
        for (int i = 0; i < 6; i++) begin
            step("ext", 1'b0, 1'b1, 1'(i % 2), 16'hFFFF, 16'h0000);
        end

        step("eq0", 1'b0, 1'b1, 1'b0, 16'h1234, 16'h1234);
        step("eq1", 1'b0, 1'b1, 1'b1, 16'h1234, 16'h1234);

        // Unknown select must fall back to in0.
        step("selx", 1'b0, 1'b1, 1'bx, 16'hC0DE, 16'hBEEF);

        // Select glitches away from 1 mid-cycle; only the value at the edge is captured.
        rst = 1'b0; in_valid = 1'b1; in0 = 16'h0F0F; in1 = 16'hF0F0; select = 1'b1;
        #2;
        select = 1'b0;
        step("glitch", 1'b0, 1'b1, 1'b0, 16'h0F0F, 16'hF0F0);

        // Mid-stream reset, then capture resumes on the next edge.
        step("pre", 1'b0, 1'b1, 1'b1, 16'h1111, 16'h7E57);
        step("mrst", 1'b1, 1'b1, 1'b1, 16'h2222, 16'h3333);
        step("post", 1'b0, 1'b1, 1'b0, 16'h4444, 16'h5555);

        // Random traffic with occasional reset.
        for (int i = 0; i < 300; i++) begin
            step("rand", 1'($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom),
                 W'($urandom), W'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mux_2to1
